hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage core. Generates the decode-stage

---
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: decode bypass selects, load-use / MDU / dmem-wait stalls and redirect flushes.
// Defining HAZARD_PERF_EN adds saturating per-cause cycle counters (perf_* outputs, CNT_W bits wide).
module hazard_ctrl #(
  parameter int MDU_LAT = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic             e_valid,
  input  logic [4:0]       e_dst,
  input  logic             e_wen,
  input  logic             e_is_load,
  input  logic             e_mdu,
  input  logic             e_redirect,
  input  logic             m_valid,
  input  logic [4:0]       m_dst,
  input  logic             m_wen,
  input  logic             dmem_wait,
  output logic             fwd_valid_a,
  output logic             fwd_valid_b,
  output logic             fwd_valid_a_,
  output logic             fwd_valid_b_,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic             dbg_mdu_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_lu_stall,
  output logic [CNT_W-1:0] perf_mdu_stall,
  output logic [CNT_W-1:0] perf_mem_stall,
  output logic [CNT_W-1:0] perf_flush
`endif
);

  // Counter holds MDU_LAT-2 at most: one cycle is spent in IDLE issuing the op.
  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT - 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 2);

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  logic e_hit1, e_hit2, m_hit1, m_hit2;
  logic fwd_a_e, fwd_b_e;
  logic load_use, redirect, mdu_start, mdu_stall;
  logic win_mem, win_mdu, win_flush, win_lu;

  // ---------------- register matches and bypass selects ----------------
  always_comb begin
    e_hit1 = e_valid & e_wen & (e_dst != 5'd0) & (e_dst == d_rs1);
    e_hit2 = e_valid & e_wen & (e_dst != 5'd0) & (e_dst == d_rs2);
    m_hit1 = m_valid & m_wen & (m_dst != 5'd0) & (m_dst == d_rs1);
    m_hit2 = m_valid & m_wen & (m_dst != 5'd0) & (m_dst == d_rs2);
    // A load's data is not available in EX, so the EX path never bypasses a load.
    fwd_a_e = e_hit1 & ~e_is_load;
    fwd_b_e = e_hit2 & ~e_is_load;
  end

  always_comb begin
    fwd_valid_a  = 1'b0;
    fwd_valid_b  = 1'b0;
    fwd_valid_a_ = 1'b0;
    fwd_valid_b_ = 1'b0;
    if (!reset) begin
      fwd_valid_a  = fwd_a_e;
      fwd_valid_b  = fwd_b_e;
      fwd_valid_a_ = m_hit1 & ~fwd_a_e;
      fwd_valid_b_ = m_hit2 & ~fwd_b_e;
    end
  end

  // ---------------- MDU busy FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign mdu_start = (state_q == MDU_IDLE) & e_valid & e_mdu & ~dmem_wait;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (mdu_start) begin
          state_d = MDU_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MDU_BUSY: begin
        // Counter keeps running under dmem_wait; it stops at zero rather than wrapping.
        if (cnt_q == '0) begin
          state_d = MDU_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mdu_busy      = (state_q == MDU_BUSY);
  assign mdu_done      = done_q;
  assign dbg_mdu_state = state_q;

  // ---------------- stall / flush arbitration ----------------
  // Exactly one cause wins per cycle: dmem_wait > MDU > redirect > load-use.
  always_comb begin
    load_use  = d_valid & e_is_load & (e_hit1 | e_hit2);
    redirect  = e_redirect & e_valid;
    mdu_stall = mdu_start | (state_q == MDU_BUSY);
    win_mem   = ~reset & dmem_wait;
    win_mdu   = ~reset & ~dmem_wait & mdu_stall;
    win_flush = ~reset & ~dmem_wait & ~mdu_stall & redirect;
    win_lu    = ~reset & ~dmem_wait & ~mdu_stall & ~redirect & load_use;
  end

  always_comb begin
    stall_f = win_mem | win_mdu | win_lu;
    stall_d = win_mem | win_mdu | win_lu;
    stall_e = win_mem | win_mdu;
    stall_m = win_mem;
    flush_d = win_flush;
    flush_e = win_flush | win_lu;
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] lu_cnt_q, mdu_cnt_q, mem_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lu_cnt_q    <= '0;
      mdu_cnt_q   <= '0;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (win_lu && (lu_cnt_q != '1))       lu_cnt_q    <= lu_cnt_q + 1'b1;
      if (win_mdu && (mdu_cnt_q != '1))     mdu_cnt_q   <= mdu_cnt_q + 1'b1;
      if (win_mem && (mem_cnt_q != '1))     mem_cnt_q   <= mem_cnt_q + 1'b1;
      if (win_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign perf_lu_stall  = lu_cnt_q;
  assign perf_mdu_stall = mdu_cnt_q;
  assign perf_mem_stall = mem_cnt_q;
  assign perf_flush     = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: bypass, load-use, MDU sequencing, dmem_wait, redirect, reset.
// Perf counter checks are compiled when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

  localparam int PERF_W = 3;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs1, d_rs2;
  logic       e_valid;
  logic [4:0] e_dst;
  logic       e_wen, e_is_load, e_mdu, e_redirect;
  logic       m_valid;
  logic [4:0] m_dst;
  logic       m_wen, dmem_wait;
  logic       fwd_valid_a, fwd_valid_b, fwd_valid_a_, fwd_valid_b_;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic       mdu_busy, mdu_done, dbg_mdu_state;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_lu_stall, perf_mdu_stall, perf_mem_stall, perf_flush;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.MDU_LAT(8), .CNT_W(PERF_W)) dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .e_valid(e_valid), .e_dst(e_dst), .e_wen(e_wen), .e_is_load(e_is_load),
    .e_mdu(e_mdu), .e_redirect(e_redirect),
    .m_valid(m_valid), .m_dst(m_dst), .m_wen(m_wen), .dmem_wait(dmem_wait),
    .fwd_valid_a(fwd_valid_a), .fwd_valid_b(fwd_valid_b),
    .fwd_valid_a_(fwd_valid_a_), .fwd_valid_b_(fwd_valid_b_),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .dbg_mdu_state(dbg_mdu_state)
`ifdef HAZARD_PERF_EN
    ,
    .perf_lu_stall(perf_lu_stall), .perf_mdu_stall(perf_mdu_stall),
    .perf_mem_stall(perf_mem_stall), .perf_flush(perf_flush)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    d_valid = 0; d_rs1 = 0; d_rs2 = 0;
    e_valid = 0; e_dst = 0; e_wen = 0; e_is_load = 0; e_mdu = 0; e_redirect = 0;
    m_valid = 0; m_dst = 0; m_wen = 0; dmem_wait = 0;
  endtask

  // EX holds a load of x3, decode reads x3 on rs1.
  task automatic drive_load_use();
    clear_inputs();
    e_valid = 1; e_wen = 1; e_is_load = 1; e_dst = 5'd3;
    d_valid = 1; d_rs1 = 5'd3;
  endtask

  function automatic logic [5:0] ctl();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};
  endfunction

  function automatic logic [3:0] fwd();
    return {fwd_valid_a, fwd_valid_b, fwd_valid_a_, fwd_valid_b_};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    clear_inputs();
    e_valid = 1; e_wen = 1; e_dst = 5'd5; d_valid = 1; d_rs1 = 5'd5; dmem_wait = 1;
    #1;
    n_tests++;
    if ({mdu_busy, mdu_done} !== 2'b00) begin
      $display("FAIL reset_mdu: got busy/done=%b expected 00", {mdu_busy, mdu_done}); n_fail++;
    end
    n_tests++;
    if ({fwd(), ctl()} !== 10'd0) begin
      $display("FAIL reset_comb: got fwd/ctl=%b expected 0", {fwd(), ctl()}); n_fail++;
    end
    @(negedge clk);
    reset = 0;
    #1;
    n_tests++;
    if ({fwd(), ctl()} !== {4'b1000, 6'b111100}) begin
      $display("FAIL reset_release: got fwd/ctl=%b expected 1000111100", {fwd(), ctl()}); n_fail++;
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    clear_inputs();
    e_valid = 1; e_wen = 1; e_dst = 5'd5; d_valid = 1; d_rs1 = 5'd5;
    #1;
    n_tests++;
    if ({fwd(), ctl()} !== {4'b1000, 6'b000000}) begin
      $display("FAIL bypass_ex_rs1: got %b expected 1000000000", {fwd(), ctl()}); n_fail++;
    end
    @(negedge clk);
    clear_inputs();
    e_valid = 1; e_wen = 1; e_dst = 5'd7; m_valid = 1; m_wen = 1; m_dst = 5'd7;
    d_valid = 1; d_rs2 = 5'd7;
    #1;
    n_tests++;
    if (fwd() !== 4'b0100) begin
      $display("FAIL bypass_ex_priority: got %b expected 0100", fwd()); n_fail++;
    end
    @(negedge clk);
    e_valid = 0;
    #1;
    n_tests++;
    if (fwd() !== 4'b0001) begin
      $display("FAIL bypass_mem_rs2: got %b expected 0001", fwd()); n_fail++;
    end
    @(negedge clk);
    clear_inputs();
    e_valid = 1; e_wen = 1; m_valid = 1; m_wen = 1; d_valid = 1;
    #1;
    n_tests++;
    if (fwd() !== 4'b0000) begin
      $display("FAIL bypass_x0: got %b expected 0000", fwd()); n_fail++;
    end
    @(negedge clk);
    clear_inputs();
    e_valid = 1; e_wen = 0; e_dst = 5'd12; d_valid = 1; d_rs1 = 5'd12; d_rs2 = 5'd12;
    #1;
    n_tests++;
    if (fwd() !== 4'b0000) begin
      $display("FAIL bypass_no_wen: got %b expected 0000", fwd()); n_fail++;
    end
    @(negedge clk);
    clear_inputs();
    e_valid = 1; e_wen = 1; e_is_load = 1; e_dst = 5'd9;
    m_valid = 1; m_wen = 1; m_dst = 5'd9; d_valid = 1; d_rs1 = 5'd9;
    #1;
    n_tests++;
    if ({fwd(), ctl()} !== {4'b0010, 6'b110001}) begin
      $display("FAIL bypass_load_in_ex: got %b expected 0010110001", {fwd(), ctl()}); n_fail++;
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive_load_use();
    #1;
    n_tests++;
    if ({fwd(), ctl()} !== {4'b0000, 6'b110001}) begin
      $display("FAIL load_use_stall: got %b expected 0000110001", {fwd(), ctl()}); n_fail++;
    end
    @(negedge clk);
    clear_inputs();
    m_valid = 1; m_wen = 1; m_dst = 5'd3; d_valid = 1; d_rs1 = 5'd3;
    #1;
    n_tests++;
    if ({fwd(), ctl()} !== {4'b0010, 6'b000000}) begin
      $display("FAIL load_use_mem_fwd: got %b expected 0010000000", {fwd(), ctl()}); n_fail++;
    end
  endtask

  task automatic test_mdu_seq();
    int se_cnt = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = -1;
    logic [5:0] first_ctl = '0;
    @(negedge clk);
    clear_inputs();
    e_valid = 1; e_mdu = 1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(negedge clk);
        e_mdu = 0;
      end
      #1;
      if (c == 0) first_ctl = ctl();
      if (stall_e) se_cnt++;
      if (mdu_busy) busy_cnt++;
      if (mdu_done) begin done_cnt++; done_at = c; end
    end
    n_tests++;
    if (first_ctl !== 6'b111000) begin
      $display("FAIL mdu_issue_ctl: got %b expected 111000", first_ctl); n_fail++;
    end
    n_tests++;
    if (se_cnt != 8) begin
      $display("FAIL mdu_stall_e_cycles: got %0d expected 8", se_cnt); n_fail++;
    end
    n_tests++;
    if (busy_cnt != 7) begin
      $display("FAIL mdu_busy_cycles: got %0d expected 7", busy_cnt); n_fail++;
    end
    n_tests++;
    if (done_cnt != 1 || done_at != 8) begin
      $display("FAIL mdu_done_pulse: got count %0d at cycle %0d expected 1 at 8", done_cnt, done_at);
      n_fail++;
    end
  endtask

  task automatic test_mdu_dmem();
    int done_at = -1;
    logic [5:0] wait_ctl = '0;
    @(negedge clk);
    clear_inputs();
    e_valid = 1; e_mdu = 1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(negedge clk);
        e_mdu = 0;
        dmem_wait = (c == 2 || c == 3);
      end
      #1;
      if (c == 2) wait_ctl = ctl();
      if (mdu_done && done_at < 0) done_at = c;
    end
    n_tests++;
    if (wait_ctl !== 6'b111100) begin
      $display("FAIL mdu_dmem_ctl: got %b expected 111100", wait_ctl); n_fail++;
    end
    n_tests++;
    if (done_at != 8) begin
      $display("FAIL mdu_dmem_counter_runs: got done at %0d expected 8", done_at); n_fail++;
    end
    @(negedge clk);
    clear_inputs();
    e_valid = 1; e_mdu = 1; dmem_wait = 1;
    @(negedge clk);
    clear_inputs();
    #1;
    n_tests++;
    if (mdu_busy !== 1'b0) begin
      $display("FAIL mdu_start_blocked: got busy=%b expected 0", mdu_busy); n_fail++;
    end
  endtask

  task automatic test_reset_mid_mdu();
    int busy_cnt = 0;
    int done_cnt = 0;
    @(negedge clk);
    clear_inputs();
    e_valid = 1; e_mdu = 1;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      e_mdu = 0;
    end
    #1;
    n_tests++;
    if (mdu_busy !== 1'b1) begin
      $display("FAIL mdu_busy_before_reset: got %b expected 1", mdu_busy); n_fail++;
    end
    @(negedge clk);
    reset = 1;
    #1;
    n_tests++;
    if ({mdu_busy, mdu_done, stall_e} !== 3'b000) begin
      $display("FAIL mdu_reset_now: got busy/done/stall_e=%b expected 000", {mdu_busy, mdu_done, stall_e});
      n_fail++;
    end
    @(negedge clk);
    reset = 0;
    clear_inputs();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (mdu_busy) busy_cnt++;
      if (mdu_done) done_cnt++;
    end
    n_tests++;
    if (busy_cnt != 0 || done_cnt != 0) begin
      $display("FAIL mdu_reset_no_done: got busy %0d done %0d expected 0 0", busy_cnt, done_cnt); n_fail++;
    end
  endtask

  task automatic test_redirect();
    @(negedge clk);
    drive_load_use();
    e_redirect = 1;
    #1;
    n_tests++;
    if (ctl() !== 6'b000011) begin
      $display("FAIL redirect_over_lu: got %b expected 000011", ctl()); n_fail++;
    end
    @(negedge clk);
    dmem_wait = 1;
    #1;
    n_tests++;
    if (ctl() !== 6'b111100) begin
      $display("FAIL redirect_dmem_wait: got %b expected 111100", ctl()); n_fail++;
    end
    @(negedge clk);
    dmem_wait = 0;
    #1;
    n_tests++;
    if (ctl() !== 6'b000011) begin
      $display("FAIL redirect_reassert: got %b expected 000011", ctl()); n_fail++;
    end
    @(negedge clk);
    e_valid = 0;
    #1;
    n_tests++;
    if (ctl() !== 6'b000000) begin
      $display("FAIL redirect_invalid_ex: got %b expected 000000", ctl()); n_fail++;
    end
    @(negedge clk);
    clear_inputs();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    reset = 1;
    clear_inputs();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_load_use();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clear_inputs();
      dmem_wait = 1;
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_tests++;
    if ({perf_lu_stall, perf_mem_stall, perf_mdu_stall, perf_flush} !== {3'd3, 3'd2, 3'd0, 3'd0}) begin
      $display("FAIL perf_counts: got lu %0d mem %0d mdu %0d flush %0d expected 3 2 0 0",
               perf_lu_stall, perf_mem_stall, perf_mdu_stall, perf_flush);
      n_fail++;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_load_use();
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_tests++;
    if ({perf_lu_stall, perf_mem_stall} !== {3'd7, 3'd2}) begin
      $display("FAIL perf_saturate: got lu %0d mem %0d expected 7 2", perf_lu_stall, perf_mem_stall);
      n_fail++;
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_bypass();
    test_load_use();
    test_mdu_seq();
    test_mdu_dmem();
    test_reset_mid_mdu();
    test_redirect();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
